// File: rtl/regfile_pkg.sv
// Shared widths and types for the 8 x 16-bit register file.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 3;
  localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO_ADDR = reg_addr_t'(0);

endpackage

// File: rtl/regfile_read_mux.sv
// Combinational NUM_REGS:1 read mux over the flattened register array.
module regfile_read_mux
  import regfile_pkg::*;
(
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]          addr,
  output logic [DATA_WIDTH-1:0]          data
);

  assign data = regs[32'(addr) * DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/register_file.sv
// 8 x 16-bit register file: two combinational read ports, one synchronous write port.
// REGFILE_R0_ZERO_EN: when defined, register 0 is hardwired to zero.
module register_file
  import regfile_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic                  sig_enable_write,
  input  logic [DATA_WIDTH-1:0] BusW,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [NUM_REGS-1:0]            write_sel;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;

  // Shift-based decode so an unknown RW propagates X into storage instead of being masked.
  assign write_sel = sig_enable_write ? (NUM_REGS'(1) << RW) : '0;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (R0_ZERO && (i == int'(REG_ZERO_ADDR))) begin : g_zero
      assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_store
      reg_data_t q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q <= '0;
        end else begin
          q <= write_sel[i] ? BusW : q;
        end
      end

      assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end
  end

  regfile_read_mux u_mux_a (
    .regs (regs_flat),
    .addr (RA),
    .data (BusA)
  );

  regfile_read_mux u_mux_b (
    .regs (regs_flat),
    .addr (RB),
    .data (BusB)
  );

  // A write with an unknown address must never be silently dropped.
  assert property (@(posedge clock) disable iff (!reset_n)
                   sig_enable_write |-> !$isunknown(RW))
    else $error("register_file: unknown write address with write enable high");

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (honours REGFILE_R0_ZERO_EN).
module tb_register_file;

  logic        clock;
  logic        reset_n;
  logic [2:0]  RA, RB, RW;
  logic        sig_enable_write;
  logic [15:0] BusW;
  logic [15:0] BusA, BusB;

  int errors = 0;
  int checks = 0;

  register_file dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .RA               (RA),
    .RB               (RB),
    .RW               (RW),
    .sig_enable_write (sig_enable_write),
    .BusW             (BusW),
    .BusA             (BusA),
    .BusB             (BusB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset;
    reset_n = 1'b0; RA = 3'd0; RB = 3'd5; RW = 3'd0;
    sig_enable_write = 1'b0; BusW = 16'h0;
    #1;
    checks++;
    if (BusA !== 16'h0) begin errors++; $display("FAIL reset_busa got=%h exp=0000", BusA); end
    checks++;
    if (BusB !== 16'h0) begin errors++; $display("FAIL reset_busb got=%h exp=0000", BusB); end
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    RA = 3'd4;
    #1;
    checks++;
    if (BusA !== 16'h0) begin errors++; $display("FAIL post_reset_r4 got=%h exp=0000", BusA); end
  endtask

  task automatic test_basic;
    @(negedge clock) begin RW = 3'd1; BusW = 16'd8; sig_enable_write = 1'b1; end
    @(negedge clock) begin RW = 3'd2; BusW = 16'd16; end
    @(negedge clock) begin sig_enable_write = 1'b0; RA = 3'd1; RB = 3'd2; end
    #1;
    checks++;
    if (BusA !== 16'd8) begin errors++; $display("FAIL basic_r1 got=%0d exp=8", BusA); end
    checks++;
    if (BusB !== 16'd16) begin errors++; $display("FAIL basic_r2 got=%0d exp=16", BusB); end
  endtask

  task automatic test_overwrite;
    @(negedge clock) begin RW = 3'd2; BusW = 16'd32; sig_enable_write = 1'b1; end
    #1;
    checks++;
    if (BusB !== 16'd16) begin errors++; $display("FAIL overwrite_pre_edge got=%0d exp=16", BusB); end
    @(posedge clock) #1;
    checks++;
    if (BusB !== 16'd32) begin errors++; $display("FAIL overwrite_post_edge got=%0d exp=32", BusB); end
    checks++;
    if (BusA !== 16'd8) begin errors++; $display("FAIL overwrite_busa got=%0d exp=8", BusA); end
    @(negedge clock) sig_enable_write = 1'b0;
  endtask

  task automatic test_write_disabled;
    @(negedge clock) begin RW = 3'd2; BusW = 16'd64; sig_enable_write = 1'b0; end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (BusB !== 16'd32) begin errors++; $display("FAIL disabled_r2 got=%0d exp=32", BusB); end
  endtask

  task automatic test_same_port;
    @(negedge clock) begin RA = 3'd1; RB = 3'd1; end
    #1;
    checks++;
    if (BusA !== 16'd8) begin errors++; $display("FAIL same_addr_busa got=%0d exp=8", BusA); end
    checks++;
    if (BusB !== 16'd8) begin errors++; $display("FAIL same_addr_busb got=%0d exp=8", BusB); end
    @(negedge clock) begin RW = 3'd7; BusW = 16'hFFFF; sig_enable_write = 1'b1; end
    @(negedge clock) begin sig_enable_write = 1'b0; RA = 3'd7; end
    #1;
    checks++;
    if (BusA !== 16'hFFFF) begin errors++; $display("FAIL full_width_r7 got=%h exp=ffff", BusA); end
  endtask

  task automatic test_r0;
    logic [15:0] exp_r0;
`ifdef REGFILE_R0_ZERO_EN
    exp_r0 = 16'h0000;
`else
    exp_r0 = 16'h1234;
`endif
    @(negedge clock) begin RW = 3'd0; BusW = 16'h1234; sig_enable_write = 1'b1; end
    @(negedge clock) begin sig_enable_write = 1'b0; RA = 3'd0; RB = 3'd1; end
    #1;
    checks++;
    if (BusA !== exp_r0) begin errors++; $display("FAIL r0_read got=%h exp=%h", BusA, exp_r0); end
    checks++;
    if (BusB !== 16'd8) begin errors++; $display("FAIL r0_write_spill_r1 got=%0d exp=8", BusB); end
  endtask

  task automatic test_reset_midrun;
    @(negedge clock) begin RA = 3'd1; RB = 3'd7; end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (BusA !== 16'h0) begin errors++; $display("FAIL midrun_reset_r1 got=%h exp=0000", BusA); end
    checks++;
    if (BusB !== 16'h0) begin errors++; $display("FAIL midrun_reset_r7 got=%h exp=0000", BusB); end
    // Attempt a write while reset is held; it must not land.
    RW = 3'd3; BusW = 16'd9; sig_enable_write = 1'b1; RA = 3'd3; RB = 3'd2;
    @(posedge clock) #1;
    checks++;
    if (BusA !== 16'h0) begin errors++; $display("FAIL write_in_reset got=%h exp=0000", BusA); end
    @(negedge clock) begin reset_n = 1'b1; sig_enable_write = 1'b0; end
    #1;
    checks++;
    if (BusA !== 16'h0) begin errors++; $display("FAIL released_r3 got=%h exp=0000", BusA); end
    checks++;
    if (BusB !== 16'h0) begin errors++; $display("FAIL released_r2 got=%h exp=0000", BusB); end
    RW = 3'd3; BusW = 16'd5; sig_enable_write = 1'b1;
    @(posedge clock) #1;
    checks++;
    if (BusA !== 16'd5) begin errors++; $display("FAIL first_write_after_reset got=%0d exp=5", BusA); end
    @(negedge clock) sig_enable_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_write_disabled();
    test_same_port();
    test_r0();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
